// File: rtl/cpu_pkg.sv
// Shared CPU definitions: hazard controller states, register-address width
// and the default data-memory timeout.
package cpu_pkg;

    localparam int REG_ADDR_W      = 3;
    localparam int DEF_MEM_TIMEOUT = 15;
    localparam int DEF_CNT_W       = 16;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERR      = 2'd2
    } haz_state_t;

endpackage

// File: rtl/hazard_match.sv
// Load-use detector: flags a decode-stage operand that reads the register an
// in-flight load in EX is about to write (the one case forwarding cannot cover).
module hazard_match
    import cpu_pkg::*;
(
    input  logic [REG_ADDR_W-1:0] op1_addr,
    input  logic [REG_ADDR_W-1:0] op2_addr,
    input  logic                  op1_used,
    input  logic                  op2_used,
    input  logic [REG_ADDR_W-1:0] dest_addr,
    input  logic                  reg_wr_en,
    input  logic                  load_true,
    output logic                  load_use
);

    logic [REG_ADDR_W-1:0] op_addr [2];
    logic [1:0]            op_used;
    logic [1:0]            op_hit;

    assign op_addr[0] = op1_addr;
    assign op_addr[1] = op2_addr;
    assign op_used    = {op2_used, op1_used};

    // r0 is deliberately not excluded: this pipeline treats it as a real register.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_op
            assign op_hit[gi] = op_used[gi] && (op_addr[gi] == dest_addr);
        end
    endgenerate

    assign load_use = reg_wr_en && load_true && (|op_hit);

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard/stall controller: memory-wait freeze with timeout, branch
// flush and load-use bubble. Define HAZ_STALL_CNT_EN to enable the stall counter.
module hazard_stall_ctrl
    import cpu_pkg::*;
#(
    parameter int MEM_TIMEOUT = DEF_MEM_TIMEOUT,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [REG_ADDR_W-1:0] op1_addr_IFID,
    input  logic [REG_ADDR_W-1:0] op2_addr_IFID,
    input  logic                  op1_used,
    input  logic                  op2_used,
    input  logic [REG_ADDR_W-1:0] dest_addr_IDEX,
    input  logic                  reg_wr_en_IDEX,
    input  logic                  load_true_IDEX,
    input  logic                  branch_taken_EX,
    input  logic                  mem_req_MEM,
    input  logic                  mem_ready,
    output logic                  stall_pc,
    output logic                  stall_IFID,
    output logic                  flush_IFID,
    output logic                  bubble_IDEX,
    output logic                  freeze_back,
    output logic                  mem_err,
    output logic [CNT_W-1:0]      stall_cycles
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

    haz_state_t        state_reg, state_next;
    logic [WAIT_W-1:0] wait_cnt_reg, wait_cnt_next;
    logic [WAIT_W-1:0] wait_cnt_inc;
    logic              load_use;
    logic              mem_wait;

    hazard_match u_hazard_match (
        .op1_addr  (op1_addr_IFID),
        .op2_addr  (op2_addr_IFID),
        .op1_used  (op1_used),
        .op2_used  (op2_used),
        .dest_addr (dest_addr_IDEX),
        .reg_wr_en (reg_wr_en_IDEX),
        .load_true (load_true_IDEX),
        .load_use  (load_use)
    );

    assign mem_wait = mem_req_MEM && !mem_ready;

    // The first waiting cycle seen from RUN counts as 1.
    assign wait_cnt_inc = (state_reg == RUN) ? WAIT_W'(1) : wait_cnt_reg + WAIT_W'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= RUN;
            wait_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        wait_cnt_next = wait_cnt_reg;
        stall_pc      = 1'b0;
        stall_IFID    = 1'b0;
        flush_IFID    = 1'b0;
        bubble_IDEX   = 1'b0;
        freeze_back   = 1'b0;
        mem_err       = 1'b0;

        case (state_reg)
            RUN, MEM_WAIT: begin
                if (mem_wait) begin
                    stall_pc      = 1'b1;
                    stall_IFID    = 1'b1;
                    freeze_back   = 1'b1;
                    wait_cnt_next = wait_cnt_inc;
                    state_next    = (wait_cnt_inc >= WAIT_W'(MEM_TIMEOUT)) ? ERR : MEM_WAIT;
                end else begin
                    // Freeze released: branch and load-use resolve in this same cycle.
                    state_next    = RUN;
                    wait_cnt_next = '0;
                    if (branch_taken_EX) begin
                        flush_IFID  = 1'b1;
                        bubble_IDEX = 1'b1;
                    end else if (load_use) begin
                        stall_pc    = 1'b1;
                        stall_IFID  = 1'b1;
                        bubble_IDEX = 1'b1;
                    end
                end
            end
            ERR: begin
                mem_err = 1'b1;
            end
            default: begin
                state_next    = RUN;
                wait_cnt_next = '0;
            end
        endcase

        if (reset) begin
            stall_pc    = 1'b0;
            stall_IFID  = 1'b0;
            flush_IFID  = 1'b0;
            bubble_IDEX = 1'b0;
            freeze_back = 1'b0;
            mem_err     = 1'b0;
        end
    end

`ifdef HAZ_STALL_CNT_EN
    logic [CNT_W-1:0] stall_cnt_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_reg <= '0;
        end else if (stall_pc && !(&stall_cnt_reg)) begin
            stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
        end
    end

    assign stall_cycles = stall_cnt_reg;
`else
    assign stall_cycles = '0;
`endif

endmodule
